ra_pq_arb2: RTL and testbench

//  Two-client arbiter/sequencer sharing one register-array priority queue port. Accepts level-held

---
 rtl/pq_pkg.sv | 9 +
 rtl/ra_pq_mux2.sv | 11 +
 rtl/ra_pq_arb2.sv | 102 ++++++++++
 tb/tb_ra_pq_arb2.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// pq_pkg: shared priority-queue item type and arbiter state/op encodings.
package pq_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;
  typedef enum logic {OP_ENQ, OP_DEQ} arb_op_t;
endpackage

// File: rtl/ra_pq_mux2.sv
// ra_pq_mux2: 2:1 kv_t steering mux, sel=0 picks a, sel=1 picks b.
module ra_pq_mux2
  import pq_pkg::*;
(
  input  logic sel,
  input  kv_t  a,
  input  kv_t  b,
  output kv_t  y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/ra_pq_arb2.sv
// ra_pq_arb2: two-client arbiter sequencing enq/deq ops onto one PQ port, with op screening and busy timeout.
module ra_pq_arb2
  import pq_pkg::*;
#(
  parameter bit RR_EN        = 1'b1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enq0,
  input  logic deq0,
  input  kv_t  kvin0,
  input  logic enq1,
  input  logic deq1,
  input  kv_t  kvin1,
  output logic ack0,
  output logic ack1,
  output logic err0,
  output logic err1,
  output kv_t  kvout,
  output logic pq_enq,
  output logic pq_deq,
  output kv_t  pq_kvin,
  input  kv_t  pq_kvout,
  input  logic pq_full,
  input  logic pq_empty,
  input  logic pq_busy
);
  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  arb_state_t state_q, state_d;
  arb_op_t    op_q, op_d;
  logic       win_q, win_d, err_q, err_d, last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  kv_t        kvout_q, kvout_d;
  logic       req0, req1, pick, e, d;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    win_d   = win_q;
    err_d   = err_q;
    last_d  = last_q;
    timer_d = timer_q;
    kvout_d = kvout_q;
    req0    = enq0 | deq0;
    req1    = enq1 | deq1;
    pick    = (req0 & req1) ? (RR_EN ? ~last_q : 1'b0) : req1;
    e       = pick ? enq1 : enq0;
    d       = pick ? deq1 : deq0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        win_d   = pick;
        op_d    = d ? OP_DEQ : OP_ENQ;
        err_d   = (e & d) | (d & pq_empty) | (e & pq_full);
        state_d = err_d ? ACK : ISSUE;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (!pq_busy) begin
        state_d = ACK;
        kvout_d = (op_q == OP_DEQ) ? pq_kvout : kvout_q;
      end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
        state_d = ACK;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
      default: begin
        last_d  = win_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ENQ;
      win_q   <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      kvout_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      win_q   <= win_d;
      err_q   <= err_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      kvout_q <= kvout_d;
    end
  end
  ra_pq_mux2 u_mux (.sel(win_q), .a(kvin0), .b(kvin1), .y(pq_kvin));
  assign ack0   = (state_q == ACK) & ~win_q;
  assign ack1   = (state_q == ACK) & win_q;
  assign err0   = ack0 & err_q;
  assign err1   = ack1 & err_q;
  assign pq_enq = (state_q == ISSUE) & (op_q == OP_ENQ);
  assign pq_deq = (state_q == ISSUE) & (op_q == OP_DEQ);
  assign kvout  = kvout_q;
endmodule

// File: tb/tb_ra_pq_arb2.sv
// tb_ra_pq_arb2: directed bench for round-robin and fixed-priority arbiters against a phase-level model.
module tb_ra_pq_arb2;
  import pq_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic enq0 = 0, deq0 = 0, enq1 = 0, deq1 = 0;
  logic pq_full = 0, pq_empty = 0, pq_busy = 0;
  kv_t  kvin0 = '0, kvin1 = '0, pq_kvout = '0;
  logic [1:0] ack0_o, ack1_o, err0_o, err1_o, pq_enq_o, pq_deq_o;
  kv_t  kvout_o [2];
  kv_t  pq_kvin_o [2];
  int   checks = 0, errors = 0;
  logic chk_en = 1'b0;
  int   m_ph [2];
  logic m_who [2], m_deq [2], m_err [2], m_last [2];
  int   m_cnt [2];
  kv_t  m_kv [2];
  int   ack_n [2], pulses [2];
  logic [7:0] seq [2];
  kv_t  last_kvin [2];
  always #5 clk = ~clk;
  ra_pq_arb2 #(.RR_EN(1'b1), .BUSY_TIMEOUT(16)) u_rr (
    .clk(clk), .rst(rst), .enq0(enq0), .deq0(deq0), .kvin0(kvin0), .enq1(enq1), .deq1(deq1),
    .kvin1(kvin1), .ack0(ack0_o[0]), .ack1(ack1_o[0]), .err0(err0_o[0]), .err1(err1_o[0]),
    .kvout(kvout_o[0]), .pq_enq(pq_enq_o[0]), .pq_deq(pq_deq_o[0]), .pq_kvin(pq_kvin_o[0]),
    .pq_kvout(pq_kvout), .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy));
  ra_pq_arb2 #(.RR_EN(1'b0), .BUSY_TIMEOUT(16)) u_fx (
    .clk(clk), .rst(rst), .enq0(enq0), .deq0(deq0), .kvin0(kvin0), .enq1(enq1), .deq1(deq1),
    .kvin1(kvin1), .ack0(ack0_o[1]), .ack1(ack1_o[1]), .err0(err0_o[1]), .err1(err1_o[1]),
    .kvout(kvout_o[1]), .pq_enq(pq_enq_o[1]), .pq_deq(pq_deq_o[1]), .pq_kvin(pq_kvin_o[1]),
    .pq_kvout(pq_kvout), .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // Model phases: 0 idle, 1 issue, 2 wait, 3 ack; index 0 is round-robin, 1 is fixed priority.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      automatic logic r0 = enq0 | deq0, r1 = enq1 | deq1, w, e, d;
      if (rst) begin
        m_ph[g] <= 0; m_last[g] <= 1'b1; m_kv[g] <= '0; m_err[g] <= 1'b0; m_who[g] <= 1'b0;
        m_deq[g] <= 1'b0; m_cnt[g] <= 0;
      end else if (m_ph[g] == 0) begin
        if (r0 || r1) begin
          w = (r0 && r1) ? ((g == 0) ? !m_last[g] : 1'b0) : r1;
          e = w ? enq1 : enq0;
          d = w ? deq1 : deq0;
          m_who[g] <= w;
          m_deq[g] <= d;
          m_err[g] <= (e && d) || (d && pq_empty) || (e && pq_full);
          m_ph[g]  <= ((e && d) || (d && pq_empty) || (e && pq_full)) ? 3 : 1;
        end
      end else if (m_ph[g] == 1) begin
        m_cnt[g] <= 0;
        m_ph[g]  <= 2;
      end else if (m_ph[g] == 2) begin
        if (!pq_busy) begin
          m_ph[g] <= 3;
          if (m_deq[g]) m_kv[g] <= pq_kvout;
        end else begin
          m_cnt[g] <= m_cnt[g] + 1;
          if (m_cnt[g] + 1 == 16) begin
            m_ph[g]  <= 3;
            m_err[g] <= 1'b1;
          end
        end
      end else begin
        m_last[g] <= m_who[g];
        m_ph[g]   <= 0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        automatic logic a = (m_ph[g] == 3);
        automatic kv_t  xk = m_who[g] ? kvin1 : kvin0;
        chk($sformatf("ack0[%0d]", g), ack0_o[g], a && !m_who[g]);
        chk($sformatf("ack1[%0d]", g), ack1_o[g], a && m_who[g]);
        chk($sformatf("err0[%0d]", g), err0_o[g], a && !m_who[g] && m_err[g]);
        chk($sformatf("err1[%0d]", g), err1_o[g], a && m_who[g] && m_err[g]);
        chk($sformatf("pq_enq[%0d]", g), pq_enq_o[g], m_ph[g] == 1 && !m_deq[g]);
        chk($sformatf("pq_deq[%0d]", g), pq_deq_o[g], m_ph[g] == 1 && m_deq[g]);
        chk($sformatf("kvout[%0d]", g), kvout_o[g], m_kv[g]);
        if (m_ph[g] == 1) chk($sformatf("pq_kvin[%0d]", g), pq_kvin_o[g], xk);
        if (ack0_o[g] || ack1_o[g]) begin
          ack_n[g] <= ack_n[g] + 1;
          seq[g]   <= {seq[g][6:0], ack1_o[g]};
        end
        if (pq_enq_o[g] || pq_deq_o[g]) begin
          pulses[g]    <= pulses[g] + 1;
          last_kvin[g] <= pq_kvin_o[g];
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_ack(input int g, input logic c, output int n, output logic e);
    logic hit = 1'b0;
    n = 0;
    e = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      if (c ? ack1_o[g] : ack0_o[g]) begin
        hit = 1'b1;
        e = c ? err1_o[g] : err0_o[g];
      end
    end
    if (!hit) n = -1;
    tick();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int n, p, b, t;
    logic e;
    ack_n = '{0, 0}; pulses = '{0, 0}; seq = '{8'h0, 8'h0}; last_kvin = '{16'h0, 16'h0};
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_outs", {ack0_o, ack1_o, err0_o, err1_o, pq_enq_o, pq_deq_o}, 0);
    chk("rst_kvout", kvout_o[0], 0);
    tick();
    rst = 1'b0;
    tick();
    // single enqueue from client 0
    kvin0 = '{key: 8'd5, val: 8'd1};
    enq0 = 1'b1;
    wait_ack(0, 1'b0, n, e);
    enq0 = 1'b0;
    chk("enq0_latency", n, 4);
    chk("enq0_err", e, 1'b0);
    chk("enq0_kvin", last_kvin[0], 16'h0501);
    // simultaneous requests after reset: client 0 first, client 1 four cycles later
    do_reset();
    kvin1 = '{key: 8'd3, val: 8'd3};
    enq0 = 1'b1; enq1 = 1'b1;
    wait_ack(0, 1'b0, n, e);
    enq0 = 1'b0;
    chk("both_first_c0", n, 4);
    wait_ack(0, 1'b1, n, e);
    enq1 = 1'b0;
    chk("both_then_c1", n, 4);
    chk("both_order", seq[1][1:0], 2'b01);
    // held continuously: RR alternates, fixed starves client 1
    do_reset();
    enq0 = 1'b1; enq1 = 1'b1;
    b = ack_n[0]; t = 0;
    while (ack_n[0] < b + 4 && t < 60) begin
      @(posedge clk);
      t++;
    end
    #2;
    enq0 = 1'b0; enq1 = 1'b0;
    chk("held_ack_count", ack_n[0] - b, 4);
    chk("rr_order", seq[0][3:0], 4'b0101);
    chk("fixed_order", seq[1][3:0], 4'b0000);
    repeat (4) tick();
    chk("held_no_extra", ack_n[0] - b, 4);
    // rejections
    p = pulses[0];
    pq_empty = 1'b1; deq1 = 1'b1;
    wait_ack(0, 1'b1, n, e);
    deq1 = 1'b0; pq_empty = 1'b0;
    chk("deq_empty_latency", n, 2);
    chk("deq_empty_err", e, 1'b1);
    pq_full = 1'b1; enq0 = 1'b1;
    wait_ack(0, 1'b0, n, e);
    enq0 = 1'b0; pq_full = 1'b0;
    chk("enq_full_latency", n, 2);
    chk("enq_full_err", e, 1'b1);
    chk("reject_no_pulse", pulses[0] - p, 0);
    // dequeue with three busy cycles
    pq_kvout = '{key: 8'd2, val: 8'd9};
    deq0 = 1'b1; pq_busy = 1'b1;
    fork
      begin
        repeat (5) @(posedge clk);
        #2 pq_busy = 1'b0;
      end
      wait_ack(0, 1'b0, n, e);
    join
    deq0 = 1'b0;
    chk("deq_busy_latency", n, 7);
    chk("deq_busy_err", e, 1'b0);
    chk("deq_kvout", kvout_o[0], 16'h0209);
    // busy never drops: timeout error, kvout held
    pq_kvout = '{key: 8'd7, val: 8'd7};
    deq0 = 1'b1; pq_busy = 1'b1;
    wait_ack(0, 1'b0, n, e);
    deq0 = 1'b0; pq_busy = 1'b0;
    chk("timeout_latency", n, 19);
    chk("timeout_err", e, 1'b1);
    chk("timeout_kvout", kvout_o[0], 16'h0209);
    // reset during WAIT abandons the op silently
    b = ack_n[0];
    deq0 = 1'b1; pq_busy = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; deq0 = 1'b0; pq_busy = 1'b0;
    @(negedge clk);
    chk("rst_wait_outs", {ack0_o[0], ack1_o[0], err0_o[0], err1_o[0], pq_enq_o[0], pq_deq_o[0]}, 0);
    chk("rst_wait_kvout", kvout_o[0], 0);
    repeat (4) tick();
    chk("rst_wait_no_ack", ack_n[0] - b, 0);
    // enq and deq together are rejected
    p = pulses[0];
    enq0 = 1'b1; deq0 = 1'b1;
    wait_ack(0, 1'b0, n, e);
    enq0 = 1'b0; deq0 = 1'b0;
    chk("enqdeq_latency", n, 2);
    chk("enqdeq_err", e, 1'b1);
    chk("enqdeq_no_pulse", pulses[0] - p, 0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
